// File: rtl/ldst_issue_sched_if.sv
// ----------------------------------------------------------------------------
// ldst_issue_sched_if
// Bundle of the dispatch, issue and retire signals of the load/store issue
// scheduler.
//   slave  : the scheduler (receives dispatch/retire, presents issue)
//   master : the surrounding pipeline (dispatch stage, AGU, retire logic)
// Signals:
//   disp0_*/disp1_* : two dispatch slots, slot 0 older than slot 1
//   disp_ready      : at least two entries are free
//   issue_*         : oldest eligible entry, valid/ready handshake
//   retire_valid    : retire the head entry
//   free_cnt        : number of free entries, 0..4
// ----------------------------------------------------------------------------
interface ldst_issue_sched_if #(
    parameter int TAG_W = 4
);
    logic             disp0_valid;
    logic             disp0_is_store;
    logic [TAG_W-1:0] disp0_tag;
    logic             disp1_valid;
    logic             disp1_is_store;
    logic [TAG_W-1:0] disp1_tag;
    logic             disp_ready;
    logic             issue_valid;
    logic [TAG_W-1:0] issue_tag;
    logic             issue_is_store;
    logic             issue_ready;
    logic             retire_valid;
    logic [2:0]       free_cnt;

    modport slave (
        input  disp0_valid, disp0_is_store, disp0_tag,
        input  disp1_valid, disp1_is_store, disp1_tag,
        input  issue_ready, retire_valid,
        output disp_ready, issue_valid, issue_tag, issue_is_store, free_cnt
    );

    modport master (
        output disp0_valid, disp0_is_store, disp0_tag,
        output disp1_valid, disp1_is_store, disp1_tag,
        output issue_ready, retire_valid,
        input  disp_ready, issue_valid, issue_tag, issue_is_store, free_cnt
    );
endinterface

// File: rtl/ldst_issue_sched.sv
// ----------------------------------------------------------------------------
// ldst_issue_sched
// 4-entry age-ordered load/store issue scheduler between dispatch and the
// AGU. A dependence matrix keeps each load waiting until every older store
// has issued. The oldest eligible entry is presented over valid/ready, and
// entries retire in order from the head.
// Ports:
//   clk     : clock
//   rst     : synchronous, active-low reset
//   flush_i : discard all entries (dispatch/issue/retire that cycle dropped)
//   bus     : dispatch / issue / retire bundle (slave side)
// ----------------------------------------------------------------------------
module ldst_issue_sched #(
    parameter int DEPTH = 4,   // only 4 supported; pointers are 2 bits
    parameter int TAG_W = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 flush_i,
    ldst_issue_sched_if.slave    bus
);
    localparam int PTR_W = 2;

    typedef logic [DEPTH-1:0] row_t;

    // Control state (reset) and payload state (not reset)
    row_t                        valid_q,    valid_d;
    row_t                        issued_q,   issued_d;
    row_t                        is_store_q, is_store_d;
    row_t [DEPTH-1:0]            dep_q,      dep_d;     // dep[i][j]: load i waits on store j
    logic [DEPTH-1:0][TAG_W-1:0] tag_q,      tag_d;
    logic [PTR_W-1:0]            head_q,     head_d;
    logic [PTR_W-1:0]            tail_q,     tail_d;
    logic [2:0]                  count_q,    count_d;

    row_t             eligible;
    logic             sel_found;
    logic [PTR_W-1:0] sel_idx;
    logic             fire;
    logic             retire_ok;
    logic             acc0;
    logic             acc1;
    logic [PTR_W-1:0] slot0;
    logic [PTR_W-1:0] slot1;
    row_t             pend_store;

    // ------------------------------------------------------------------
    // Eligibility and oldest-first selection (registered state only)
    // ------------------------------------------------------------------
    always_comb begin
        for (int i = 0; i < DEPTH; i++) begin
            eligible[i] = valid_q[i] & ~issued_q[i] & (is_store_q[i] | ~|dep_q[i]);
        end
    end

    always_comb begin
        // NOTE: every variable written in an always_comb gets a default
        // first, so no path leaves it unassigned and no latch is inferred.
        sel_found = 1'b0;
        sel_idx   = head_q;
        for (int k = 0; k < DEPTH; k++) begin
            automatic logic [PTR_W-1:0] p = head_q + PTR_W'(k);  // wraps mod 4
            if (!sel_found && eligible[p]) begin
                sel_found = 1'b1;
                sel_idx   = p;
            end
        end
    end

    assign bus.issue_valid    = sel_found;
    assign bus.issue_tag      = tag_q[sel_idx];
    assign bus.issue_is_store = is_store_q[sel_idx];
    assign bus.disp_ready     = (count_q <= 3'd2);
    assign bus.free_cnt       = 3'(DEPTH) - count_q;

    // ------------------------------------------------------------------
    // Handshake decode
    // ------------------------------------------------------------------
    assign fire      = sel_found & bus.issue_ready;
    assign retire_ok = bus.retire_valid & valid_q[head_q] & issued_q[head_q];
    assign acc0      = bus.disp_ready & bus.disp0_valid;
    assign acc1      = acc0 & bus.disp1_valid;
    assign slot0     = tail_q;
    assign slot1     = tail_q + PTR_W'(1);

    // ------------------------------------------------------------------
    // Next state
    // ------------------------------------------------------------------
    always_comb begin
        valid_d    = valid_q;
        issued_d   = issued_q;
        is_store_d = is_store_q;
        dep_d      = dep_q;
        tag_d      = tag_q;
        head_d     = head_q;
        tail_d     = tail_q;
        count_d    = count_q;

        // Stores still lacking an address, as seen after this cycle's fire
        for (int j = 0; j < DEPTH; j++) begin
            pend_store[j] = valid_q[j] & is_store_q[j] & ~issued_q[j];
        end

        if (fire) begin
            issued_d[sel_idx]   = 1'b1;
            pend_store[sel_idx] = 1'b0;
            if (is_store_q[sel_idx]) begin
                for (int i = 0; i < DEPTH; i++) begin
                    dep_d[i][sel_idx] = 1'b0;
                end
            end
        end

        if (retire_ok) begin
            valid_d[head_q] = 1'b0;
            head_d          = head_q + PTR_W'(1);
        end

        // disp_ready guarantees slots tail and tail+1 are free
        if (acc0) begin
            valid_d[slot0]    = 1'b1;
            issued_d[slot0]   = 1'b0;
            is_store_d[slot0] = bus.disp0_is_store;
            tag_d[slot0]      = bus.disp0_tag;
            dep_d[slot0]      = bus.disp0_is_store ? '0 : pend_store;
        end
        if (acc1) begin
            valid_d[slot1]    = 1'b1;
            issued_d[slot1]   = 1'b0;
            is_store_d[slot1] = bus.disp1_is_store;
            tag_d[slot1]      = bus.disp1_tag;
            // A slot-1 load also waits on a same-cycle slot-0 store
            dep_d[slot1]      = bus.disp1_is_store ? '0 :
                                (pend_store | (bus.disp0_is_store ? (row_t'(1) << slot0) : '0));
        end

        tail_d  = tail_q + PTR_W'(acc0) + PTR_W'(acc1);
        count_d = count_q + 3'(acc0) + 3'(acc1) - 3'(retire_ok);

        if (flush_i) begin
            valid_d  = '0;
            issued_d = '0;
            dep_d    = '0;
            head_d   = '0;
            tail_d   = '0;
            count_d  = '0;
        end
    end

    // ------------------------------------------------------------------
    // State registers
    // ------------------------------------------------------------------
    // NOTE: sequential state uses non-blocking assignments so every
    // register samples its next value from the same pre-edge state.
    always_ff @(posedge clk) begin
        if (!rst) begin
            valid_q  <= '0;
            issued_q <= '0;
            dep_q    <= '0;
            head_q   <= '0;
            tail_q   <= '0;
            count_q  <= '0;
        end else begin
            valid_q  <= valid_d;
            issued_q <= issued_d;
            dep_q    <= dep_d;
            head_q   <= head_d;
            tail_q   <= tail_d;
            count_q  <= count_d;
        end
    end

    // NOTE: payload storage is not reset; it is only ever read behind a
    // valid bit, so clearing it would add reset fan-out for no benefit.
    always_ff @(posedge clk) begin
        is_store_q <= is_store_d;
        tag_q      <= tag_d;
    end

endmodule

// File: tb/tb_ldst_issue_sched.sv
// ----------------------------------------------------------------------------
// tb_ldst_issue_sched
// Directed self-checking bench for ldst_issue_sched. Inputs change 1 time
// unit after each rising edge; outputs are checked at the same point, i.e.
// they reflect the state updated at that edge.
// ----------------------------------------------------------------------------
module tb_ldst_issue_sched;
    logic clk;
    logic rst;
    logic flush;

    int n_checks = 0;
    int n_errors = 0;

    ldst_issue_sched_if #(.TAG_W(4)) bus ();

    ldst_issue_sched #(.DEPTH(4), .TAG_W(4)) dut (
        .clk     (clk),
        .rst     (rst),
        .flush_i (flush),
        .bus     (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic disp(input logic v0, input logic s0, input logic [3:0] t0,
                        input logic v1, input logic s1, input logic [3:0] t1);
        bus.disp0_valid    = v0;
        bus.disp0_is_store = s0;
        bus.disp0_tag      = t0;
        bus.disp1_valid    = v1;
        bus.disp1_is_store = s1;
        bus.disp1_tag      = t1;
    endtask

    task automatic disp_clear();
        disp(1'b0, 1'b0, 4'd0, 1'b0, 1'b0, 4'd0);
    endtask

    initial begin
        rst              = 1'b0;
        flush            = 1'b0;
        bus.issue_ready  = 1'b0;
        bus.retire_valid = 1'b0;
        disp_clear();

        // ---------------- Reset, idle ----------------
        tick();
        tick();
        rst = 1'b1;
        tick();
        check("rst_issue_valid", bus.issue_valid, 1'b0);
        check("rst_disp_ready",  bus.disp_ready,  1'b1);
        check("rst_free_cnt",    bus.free_cnt,    3'd4);

        // ---------------- Two loads, tags 1 and 2 ----------------
        disp(1'b1, 1'b0, 4'd1, 1'b1, 1'b0, 4'd2);
        tick();
        disp_clear();
        check("t1_valid",   bus.issue_valid, 1'b1);
        check("t1_tag1",    bus.issue_tag,   4'd1);
        check("t1_free",    bus.free_cnt,    3'd2);
        bus.issue_ready = 1'b1;
        tick();                                   // L1 fires
        check("t1_tag2",    bus.issue_tag,   4'd2);
        tick();                                   // L2 fires
        check("t1_empty",   bus.issue_valid, 1'b0);
        bus.issue_ready  = 1'b0;
        bus.retire_valid = 1'b1;
        tick();
        tick();
        bus.retire_valid = 1'b0;
        check("t1_free4",   bus.free_cnt,    3'd4);

        // ---------------- Store 3 + load 4, AGU stalled ----------------
        disp(1'b1, 1'b1, 4'd3, 1'b1, 1'b0, 4'd4);
        tick();
        disp_clear();
        check("t2_tag3",    bus.issue_tag,      4'd3);
        check("t2_is_st",   bus.issue_is_store, 1'b1);
        tick();
        tick();
        tick();
        check("t2_hold_v",  bus.issue_valid,    1'b1);
        check("t2_hold",    bus.issue_tag,      4'd3);
        bus.issue_ready = 1'b1;
        tick();                                   // S3 fires
        check("t2_tag4",    bus.issue_tag,      4'd4);
        check("t2_is_ld",   bus.issue_is_store, 1'b0);
        tick();                                   // L4 fires
        bus.issue_ready = 1'b0;
        check("t2_empty",   bus.issue_valid,    1'b0);
        bus.retire_valid = 1'b1;
        tick();
        tick();
        bus.retire_valid = 1'b0;
        check("t2_free4",   bus.free_cnt,       3'd4);

        // ---------------- Fill: S5 L6 S7 L8 ----------------
        disp(1'b1, 1'b1, 4'd5, 1'b1, 1'b0, 4'd6);
        tick();
        check("t3_free2",   bus.free_cnt,   3'd2);
        disp(1'b1, 1'b1, 4'd7, 1'b1, 1'b0, 4'd8);
        tick();
        check("t3_full_rdy", bus.disp_ready, 1'b0);
        check("t3_full_cnt", bus.free_cnt,   3'd0);
        disp(1'b1, 1'b0, 4'd11, 1'b1, 1'b0, 4'd12);   // must be ignored
        tick();
        disp_clear();
        check("t3_ign_cnt", bus.free_cnt,   3'd0);
        check("t3_tag5",    bus.issue_tag,  4'd5);
        bus.issue_ready = 1'b1;
        tick();                                   // S5 fires
        check("t3_tag6",    bus.issue_tag,  4'd6);
        tick();                                   // L6 fires
        check("t3_tag7",    bus.issue_tag,  4'd7);
        tick();                                   // S7 fires
        check("t3_tag8",    bus.issue_tag,  4'd8);
        tick();                                   // L8 fires
        check("t3_empty",   bus.issue_valid, 1'b0);
        bus.issue_ready  = 1'b0;
        bus.retire_valid = 1'b1;
        tick();
        tick();
        tick();
        tick();
        bus.retire_valid = 1'b0;
        check("t3_free4",   bus.free_cnt,   3'd4);

        // ---------------- Wrap-around: 6 store/load rounds ----------------
        for (int r = 1; r <= 6; r++) begin
            automatic logic [3:0] ta = 4'(2 * r);
            automatic logic [3:0] tb = 4'(2 * r + 1);
            disp(1'b1, 1'b1, ta, 1'b1, 1'b0, tb);
            tick();
            disp_clear();
            check("t4_first",  bus.issue_tag, ta);
            bus.issue_ready = 1'b1;
            tick();
            check("t4_second", bus.issue_tag, tb);
            tick();
            check("t4_empty",  bus.issue_valid, 1'b0);
            bus.issue_ready  = 1'b0;
            bus.retire_valid = 1'b1;
            tick();
            tick();
            bus.retire_valid = 1'b0;
        end
        check("t4_free4",   bus.free_cnt,   3'd4);

        // ---------------- S9 fires while L10 dispatches ----------------
        disp(1'b1, 1'b1, 4'd9, 1'b0, 1'b0, 4'd0);
        tick();
        check("t5_tag9",    bus.issue_tag,  4'd9);
        bus.issue_ready = 1'b1;
        disp(1'b1, 1'b0, 4'd10, 1'b0, 1'b0, 4'd0);
        tick();                                   // S9 fires, L10 written
        bus.issue_ready = 1'b0;
        disp_clear();
        check("t5_v10",     bus.issue_valid, 1'b1);
        check("t5_tag10",   bus.issue_tag,   4'd10);

        // Retire S9 and dispatch L11 in one cycle: count stays 2
        bus.retire_valid = 1'b1;
        disp(1'b1, 1'b0, 4'd11, 1'b0, 1'b0, 4'd0);
        tick();
        bus.retire_valid = 1'b0;
        check("t5_ret_disp", bus.free_cnt,  3'd2);
        check("t5_still10",  bus.issue_tag, 4'd10);
        disp(1'b1, 1'b0, 4'd12, 1'b0, 1'b0, 4'd0);
        tick();
        disp_clear();
        check("t5_free1",   bus.free_cnt,   3'd1);
        check("t5_nrdy",    bus.disp_ready, 1'b0);

        // Retire on unissued head (L10) ignored; dispatch at count 3 ignored
        bus.retire_valid = 1'b1;
        disp(1'b1, 1'b0, 4'd13, 1'b0, 1'b0, 4'd0);
        tick();
        bus.retire_valid = 1'b0;
        disp_clear();
        check("t5_ret_ign", bus.free_cnt,   3'd1);

        // ---------------- Flush with 3 entries, fire + dispatch dropped ----
        flush           = 1'b1;
        bus.issue_ready = 1'b1;
        disp(1'b1, 1'b1, 4'd13, 1'b0, 1'b0, 4'd0);
        tick();
        flush           = 1'b0;
        bus.issue_ready = 1'b0;
        disp_clear();
        check("t6_free4",   bus.free_cnt,    3'd4);
        check("t6_ivalid",  bus.issue_valid, 1'b0);
        check("t6_rdy",     bus.disp_ready,  1'b1);

        // Fresh queue after flush: a load with no older store is eligible
        disp(1'b1, 1'b0, 4'd14, 1'b0, 1'b0, 4'd0);
        tick();
        disp_clear();
        check("t6_tag14",   bus.issue_tag,   4'd14);
        check("t6_free3",   bus.free_cnt,    3'd3);

        // ---------------- Reset mid-operation ----------------
        rst = 1'b0;
        tick();
        rst = 1'b1;
        check("t7_ivalid",  bus.issue_valid, 1'b0);
        check("t7_free4",   bus.free_cnt,    3'd4);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
